hazard_forward_unit: RTL
========================

// Module: hazard_forward_unit
// PURPOSE
//  Control-side partner of the EXE stage: generates the val1Forward/val2Forward/src2_valForward
//  selects, the load-use stall and the branch flush that the EXE stage consumes.
//  Keeps a shadow of in-flight instructions (EXE, MEM, WB slots) from the ID-stage fields.
//  Sits beside ID/EXE; outputs drive the EXE muxes, PC/IF-ID hold and the ID/EXE bubble insert.
// PARAMETERS
//  REG_AW  5   register-address width
//  CNT_W   16  width of stall/flush performance counters
// PORTS
//  clk            in   1       clock, rising edge
//  rst_n          in   1       asynchronous active-low reset
//  id_valid       in   1       ID holds a real instruction
//  id_src1        in   REG_AW  rs for val1
//  id_src2        in   REG_AW  register for val2 (valid only if id_use_src2)
//  id_src_st      in   REG_AW  register for val_src2 (store data / branch compare)
//  id_use_src1/2  in   1 each  operand read from register file (not immediate/PC)
//  id_use_st      in   1       val_src2 is consumed
//  id_dest        in   REG_AW  destination register
//  id_wb_en       in   1       instruction writes back
//  id_mem_r_en    in   1       instruction is a load
//  br_taken       in   1       Br_taken from EXE stage
//  val1_fwd       out  2       0=regfile, 1=exeStVal (MEM slot), 2=memStVal (WB slot)
//  val2_fwd       out  2       same encoding, for val2
//  src2_val_fwd   out  2       same encoding, for val_src2
//  stall          out  1       hold PC and IF/ID; bubble into ID/EXE
//  flush          out  1       squash IF/ID and the ID instruction
//  stall_count    out  CNT_W   saturating count of stall cycles
//  flush_count    out  CNT_W   saturating count of flush cycles
// BEHAVIOUR
//  - Slots EXE/MEM/WB each hold {valid, src1, src2, src_st, use flags, dest, wb_en, mem_r_en}.
//  - Reset: all slots invalid; every output 0; counters 0. Takes effect immediately, mid-run too.
//  - Each edge: WB<=MEM, MEM<=EXE; EXE<=ID fields if id_valid & ~stall & ~flush, else bubble.
//  - A slot "writes R" iff valid & wb_en & dest==R & R!=0. Register 0 never forwards/stalls.
//  - Forward selects: combinational from registered slots only, for the EXE slot's sources:
//    MEM slot writes src -> 1; else WB slot writes src -> 2; else 0.
//    Selects are 0 when EXE slot is invalid or the matching use flag is 0. MEM beats WB.
//  - stall = id_valid & EXE slot is load writing a used ID source (src1/src2/src_st) & ~br_taken.
//    Exactly one bubble per load-use; next cycle the consumer sees select=2 from WB.
//  - flush = br_taken (same cycle). Flush overrides stall; ID instruction is dropped.
//  - Regfile is write-before-read; WB slot vs ID needs no stall or forward.
//  - Counters increment on cycles with stall / flush; saturate at all-ones, never wrap.
// CONFIGURATION
//  HAZARD_FORWARDING_EN defined: behaviour above.
//  Not defined: all *_fwd outputs tied 0; stall = id_valid & (EXE or MEM slot writes a used ID
//  source) & ~br_taken. Dependences 1 or 2 instructions apart therefore cost 2 or 1 bubbles.
// TESTING
//  1 ADD r1,r2,r3 ; ADD r4,r1,r5 -> 2nd in EXE: val1_fwd=1, val2_fwd=0, stall never 1.
//  2 ADD r1,.. ; NOP ; SUB r6,r7,r1 -> SUB in EXE: val2_fwd=2; with id_use_src2=0 -> 0.
//  3 ADD r1 ; ADD r1 ; SW r1 (src_st=r1) -> SW in EXE: src2_val_fwd=1 (MEM beats WB).
//  4 LW r4 ; ADD r5,r4,r6 -> stall=1 exactly 1 cycle, bubble, then val1_fwd=2; stall_count=1.
//  5 LW r4 in EXE, ID uses r4, br_taken=1 same cycle -> flush=1, stall=0, EXE slot bubble
//    next edge, flush_count=1, stall_count unchanged.
//  6 dest=r0 writers -> all selects 0; rst_n low mid-stream -> outputs 0 at once, slots empty;
//    macro undefined: test 1 gives stall=1 for 2 cycles, all selects 0.

Source files
------------

// File: rtl/hazard_forward_unit.sv
// Hazard/forwarding control beside ID/EXE: operand forward selects, load-use stall, branch flush.
// Define HAZARD_FORWARDING_EN for forwarding; otherwise selects are 0 and RAW hazards stall.
module hazard_forward_unit #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_src1,
    input  logic [REG_AW-1:0] id_src2,
    input  logic [REG_AW-1:0] id_src_st,
    input  logic              id_use_src1,
    input  logic              id_use_src2,
    input  logic              id_use_st,
    input  logic [REG_AW-1:0] id_dest,
    input  logic              id_wb_en,
    input  logic              id_mem_r_en,
    input  logic              br_taken,
    output logic [1:0]        val1_fwd,
    output logic [1:0]        val2_fwd,
    output logic [1:0]        src2_val_fwd,
    output logic              stall,
    output logic              flush,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] src1;
        logic [REG_AW-1:0] src2;
        logic [REG_AW-1:0] src_st;
        logic              use1;
        logic              use2;
        logic              use_st;
        logic [REG_AW-1:0] dest;
        logic              wb_en;
        logic              mem_r_en;
    } slot_t;

    // Later slots only need their write-back identity.
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] dest;
        logic              wb_en;
    } wr_t;

    slot_t exe_q;
    slot_t id_slot;
    wr_t   mem_q;

    function automatic wr_t to_wr(input slot_t s);
        return '{valid: s.valid, dest: s.dest, wb_en: s.wb_en};
    endfunction

    function automatic logic writes(input wr_t w, input logic [REG_AW-1:0] r);
        return w.valid & w.wb_en & (w.dest == r) & (r != '0);
    endfunction

    function automatic logic writes_used(input wr_t w, input slot_t c);
        return (c.use1 & writes(w, c.src1)) | (c.use2 & writes(w, c.src2)) |
               (c.use_st & writes(w, c.src_st));
    endfunction

    assign id_slot = '{valid: id_valid, src1: id_src1, src2: id_src2, src_st: id_src_st,
                       use1: id_use_src1, use2: id_use_src2, use_st: id_use_st,
                       dest: id_dest, wb_en: id_wb_en, mem_r_en: id_mem_r_en};

    assign flush = br_taken & rst_n;

`ifdef HAZARD_FORWARDING_EN
    wr_t wb_q;

    function automatic logic [1:0] fwd_sel(input logic en, input logic [REG_AW-1:0] r,
                                           input wr_t mem, input wr_t wb);
        if (en && writes(mem, r)) return 2'd1;
        if (en && writes(wb, r))  return 2'd2;
        return 2'd0;
    endfunction

    assign val1_fwd     = fwd_sel(exe_q.valid & exe_q.use1, exe_q.src1, mem_q, wb_q);
    assign val2_fwd     = fwd_sel(exe_q.valid & exe_q.use2, exe_q.src2, mem_q, wb_q);
    assign src2_val_fwd = fwd_sel(exe_q.valid & exe_q.use_st, exe_q.src_st, mem_q, wb_q);

    // Only a load in EXE cannot be forwarded in time.
    assign stall = id_valid & exe_q.mem_r_en & writes_used(to_wr(exe_q), id_slot) & ~br_taken;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_q <= '0;
        end else begin
            wb_q <= mem_q;
        end
    end
`else
    assign val1_fwd     = 2'd0;
    assign val2_fwd     = 2'd0;
    assign src2_val_fwd = 2'd0;

    // WB is covered by write-before-read; EXE and MEM results must drain first.
    assign stall = id_valid & (writes_used(to_wr(exe_q), id_slot) | writes_used(mem_q, id_slot))
                   & ~br_taken;

    logic unused_exe;
    assign unused_exe = ^{exe_q.src1, exe_q.src2, exe_q.src_st, exe_q.use1, exe_q.use2,
                          exe_q.use_st, exe_q.mem_r_en};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exe_q <= '0;
            mem_q <= '0;
        end else begin
            exe_q <= (id_valid && !stall && !flush) ? id_slot : '0;
            mem_q <= to_wr(exe_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stall && (stall_count != '1)) stall_count <= stall_count + 1'b1;
            if (flush && (flush_count != '1)) flush_count <= flush_count + 1'b1;
        end
    end

endmodule
